// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-port register file.
package regfile_pkg;
  localparam int DATA_SIZE_D    = 32;
  localparam int NUM_REG_D      = 32;
  localparam int ADDRESS_SIZE_D = 5;
  localparam int NUM_READ_D     = 2;
  // x0 is hardwired to zero and never tracked by the scoreboard.
  localparam int ZERO_REG       = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with
// flush > issue-set > write-clear priority and per-port lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REG      = NUM_REG_D,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_D,
  parameter int NUM_READ     = NUM_READ_D
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             issue_en,
  input  logic [ADDRESS_SIZE-1:0]          issue_addr,
  input  logic                             wr_en,    // already qualified: nonzero, in range
  input  logic [ADDRESS_SIZE-1:0]          wr_addr,
  input  logic [NUM_READ*ADDRESS_SIZE-1:0] rd_addr,
  input  logic [NUM_READ-1:0]              fwd,      // port is being served by the bypass
  output logic [NUM_READ-1:0]              busy_r
);

  logic [NUM_REG-1:0] busy, busy_nxt;
  logic               iss_ok;

  assign iss_ok = issue_en && (issue_addr != ADDRESS_SIZE'(ZERO_REG)) &&
                  (32'(issue_addr) < NUM_REG);

  // Next busy vector: a new producer overrides a same-cycle writeback.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)  busy_nxt[wr_addr]    = 1'b0;
      if (iss_ok) busy_nxt[issue_addr] = 1'b1;
    end
  end

  // Busy vector register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_lookup
    logic [ADDRESS_SIZE-1:0] a;
    assign a         = rd_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
    // A forwarded operand is not a hazard; out-of-range reads are never busy.
    assign busy_r[i] = !fwd[i] && (32'(a) < NUM_REG) && busy[a];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with same-cycle write bypass
// and pending-write scoreboard for decode-stage stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_D,
  parameter int NUM_REG      = NUM_REG_D,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_D,
  parameter int NUM_READ     = NUM_READ_D,
  parameter bit BYPASS       = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             RegWEn,
  input  logic [ADDRESS_SIZE-1:0]          AddrD,
  input  logic [DATA_SIZE-1:0]             DataD,
  input  logic [NUM_READ*ADDRESS_SIZE-1:0] AddrR,
  output logic [NUM_READ*DATA_SIZE-1:0]    DataR,
  output logic [NUM_READ-1:0]              BusyR,
  input  logic                             IssueEn,
  input  logic [ADDRESS_SIZE-1:0]          IssueAddr,
  input  logic                             Flush
);

  logic [NUM_REG-1:0][DATA_SIZE-1:0] regs;
  logic                              wr_ok;
  logic [NUM_READ-1:0]               fwd;

  // Writes to x0 or to nonexistent registers are dropped here once.
  assign wr_ok = RegWEn && (AddrD != ADDRESS_SIZE'(ZERO_REG)) && (32'(AddrD) < NUM_REG);

  // Storage array; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     regs <= '0;
    else if (wr_ok) regs[AddrD] <= DataD;
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDRESS_SIZE-1:0] a;
    logic                    ok;
    assign a      = AddrR[i*ADDRESS_SIZE +: ADDRESS_SIZE];
    assign ok     = (a != ADDRESS_SIZE'(ZERO_REG)) && (32'(a) < NUM_REG);
    // wr_ok already implies a nonzero, in-range destination.
    assign fwd[i] = BYPASS && wr_ok && (AddrD == a);
    // Gate with rst_n so a bypassed write cannot leak out during reset.
    assign DataR[i*DATA_SIZE +: DATA_SIZE] =
      !rst_n ? '0 : fwd[i] ? DataD : ok ? regs[a] : '0;
  end

  regfile_scoreboard #(
    .NUM_REG      (NUM_REG),
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .NUM_READ     (NUM_READ)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (Flush),
    .issue_en   (IssueEn),
    .issue_addr (IssueAddr),
    .wr_en      (wr_ok),
    .wr_addr    (AddrD),
    .rd_addr    (AddrR),
    .fwd        (fwd),
    .busy_r     (BusyR)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench: two register files (bypass on / 32 regs, bypass off / 24 regs)
// driven in lockstep, checked against an array model through a queue.
module tb_regfile_mp;
  logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0, iss = 1'b0, fl = 1'b0;
  logic [4:0]  ad = '0, ia = '0;
  logic [31:0] dd = '0;
  logic [9:0]  ar = '0;
  logic [63:0] dr0, dr1;
  logic [1:0]  br0, br1;

  int errors = 0, checks = 0;

  typedef struct {
    string       nm;
    logic [31:0] d[2][2];
    logic        b[2][2];
  } exp_t;
  exp_t q[$];

  // model state, one copy per DUT
  logic [31:0] mem[2][32];
  bit          bsy[2][32];
  int          nreg[2] = '{32, 24};
  bit          byp[2]  = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .RegWEn(we), .AddrD(ad), .DataD(dd), .AddrR(ar),
    .DataR(dr0), .BusyR(br0), .IssueEn(iss), .IssueAddr(ia), .Flush(fl));

  regfile_mp #(.NUM_REG(24), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .RegWEn(we), .AddrD(ad), .DataD(dd), .AddrR(ar),
    .DataR(dr1), .BusyR(br1), .IssueEn(iss), .IssueAddr(ia), .Flush(fl));

  function automatic logic [31:0] m_read(int x, logic [4:0] a);
    if (!rst_n || a == 0 || int'(a) >= nreg[x]) return 32'h0;
    if (byp[x] && we && ad == a) return dd;
    return mem[x][a];
  endfunction

  function automatic logic m_busy(int x, logic [4:0] a);
    if (!rst_n || a == 0 || int'(a) >= nreg[x]) return 1'b0;
    if (byp[x] && we && ad == a) return 1'b0;
    return bsy[x][a];
  endfunction

  task automatic m_update();
    for (int x = 0; x < 2; x++) begin
      if (!rst_n) begin
        for (int r = 0; r < 32; r++) begin mem[x][r] = '0; bsy[x][r] = 1'b0; end
      end else begin
        bit w_ok = we && ad != 0 && int'(ad) < nreg[x];
        if (w_ok) mem[x][ad] = dd;
        if (fl) begin
          for (int r = 0; r < 32; r++) bsy[x][r] = 1'b0;
        end else begin
          if (w_ok) bsy[x][ad] = 1'b0;
          if (iss && ia != 0 && int'(ia) < nreg[x]) bsy[x][ia] = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, then advance the model at the edge.
  task automatic step(input logic rs, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r0, input logic [4:0] r1, input logic is,
                      input logic [4:0] isa, input logic f, input string nm);
    exp_t e;
    rst_n = rs; we = w; ad = a; dd = d; ar = {r1, r0}; iss = is; ia = isa; fl = f;
    #1;
    e.nm = nm;
    for (int x = 0; x < 2; x++)
      for (int p = 0; p < 2; p++) begin
        logic [4:0] ra;
        ra = ar[p*5 +: 5];
        e.d[x][p] = m_read(x, ra);
        e.b[x][p] = m_busy(x, ra);
      end
    q.push_back(e);
    @(posedge clk);
    m_update();
    #1;
  endtask

  // Monitor: compare whatever the DUTs present against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      for (int x = 0; x < 2; x++)
        for (int p = 0; p < 2; p++) begin
          logic [31:0] ad_;
          logic        ab_;
          ad_ = (x == 0) ? dr0[p*32 +: 32] : dr1[p*32 +: 32];
          ab_ = (x == 0) ? br0[p] : br1[p];
          checks++;
          if (ad_ !== e.d[x][p]) begin
            errors++;
            $display("FAIL %s dut%0d port%0d DataR got %h want %h", e.nm, x, p, ad_, e.d[x][p]);
          end
          checks++;
          if (ab_ !== e.b[x][p]) begin
            errors++;
            $display("FAIL %s dut%0d port%0d BusyR got %b want %b", e.nm, x, p, ab_, e.b[x][p]);
          end
        end
    end
  end

  initial begin
    for (int x = 0; x < 2; x++)
      for (int r = 0; r < 32; r++) begin mem[x][r] = '0; bsy[x][r] = 1'b0; end
    @(posedge clk); #1;
    // reset hold
    step(0, 1, 5, 32'h1234, 5, 7, 1, 5, 0, "rst_hold");
    step(0, 0, 0, 0, 5, 7, 0, 0, 0, "rst_hold2");
    // preload, then asynchronous reset mid-cycle
    step(1, 1, 5, 32'h55, 5, 5, 0, 0, 0, "pre_w5");
    step(1, 1, 7, 32'h77, 5, 7, 1, 5, 0, "pre_w7");
    step(1, 0, 0, 0, 5, 7, 0, 0, 0, "pre_rd");
    step(0, 0, 0, 0, 5, 7, 0, 0, 0, "rst_mid");
    step(1, 0, 0, 0, 5, 7, 0, 0, 0, "rst_after");
    // write with bypass / without bypass
    step(1, 1, 7, 32'hDEADBEEF, 7, 5, 0, 0, 0, "byp_w");
    step(1, 0, 0, 0, 7, 7, 0, 0, 0, "byp_next");
    // x0 guard
    step(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, "x0_w");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, "x0_iss");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "x0_rd");
    // scoreboard set / clear / same-cycle issue+write
    step(1, 0, 0, 0, 3, 0, 1, 3, 0, "sb_iss");
    step(1, 0, 0, 0, 3, 0, 0, 0, 0, "sb_b1");
    step(1, 0, 0, 0, 3, 3, 0, 0, 0, "sb_b2");
    step(1, 1, 3, 32'h33, 3, 0, 0, 0, 0, "sb_wr");
    step(1, 0, 0, 0, 3, 0, 0, 0, 0, "sb_clr");
    step(1, 1, 3, 32'h34, 3, 0, 1, 3, 0, "sb_same");
    step(1, 0, 0, 0, 3, 3, 0, 0, 0, "sb_same_after");
    // flush beats issue, write data still commits
    step(1, 0, 0, 0, 3, 9, 1, 9, 0, "fl_iss9");
    step(1, 0, 0, 0, 9, 12, 1, 12, 0, "fl_iss12");
    step(1, 1, 9, 32'h11, 9, 15, 1, 15, 1, "fl");
    step(1, 0, 0, 0, 9, 15, 0, 0, 0, "fl_a");
    step(1, 0, 0, 0, 3, 12, 0, 0, 0, "fl_b");
    // addresses beyond the 24-entry instance
    step(1, 1, 28, 32'hABCD, 28, 0, 0, 0, 0, "oor_w");
    step(1, 0, 0, 0, 28, 28, 1, 28, 0, "oor_iss");
    step(1, 0, 0, 0, 28, 23, 1, 23, 0, "oor_rd");
    step(1, 0, 0, 0, 28, 23, 0, 0, 0, "edge23");
    // randomized traffic, addresses biased onto a small pool to provoke hits
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a, r0, r1, isa;
      logic       rs;
      a   = 5'($urandom_range(0, 31));
      isa = ($urandom % 4 == 0) ? a : 5'($urandom_range(0, 31));
      r0  = ($urandom % 3 == 0) ? a : 5'($urandom_range(0, 31));
      r1  = ($urandom % 3 == 0) ? isa : 5'($urandom_range(0, 31));
      rs  = ($urandom % 100 != 0);
      step(rs, 1'($urandom % 2), a, $urandom, r0, r1, 1'($urandom % 3 == 0), isa,
           1'($urandom % 25 == 0), "rand");
    end
    // drain, bounded
    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
